// File: rtl/snapshot_pkg.sv
// Shared types and constants for the register snapshot server: FSM states,
// read-output source select and the word map of the captured CPU state.
package snapshot_pkg;

  typedef enum logic [1:0] {
    FILL,
    PENDING,
    SWAP
  } state_t;

  // Source of register_value for the read issued on the previous cycle.
  typedef enum logic [2:0] {
    OUT_ZERO,
    OUT_OOR,
    OUT_BANK0,
    OUT_BANK1,
    OUT_SEQ
  } out_sel_t;

  localparam logic [31:0] OOR_DEFAULT = 32'h0000_0000;

  localparam int GPR_BASE   = 0;
  localparam int PC_IDX     = 32;
  localparam int INSTR_IDX  = 33;
  localparam int STATUS_IDX = 34;

endpackage

// File: rtl/snapshot_bank_ram.sv
// One snapshot bank: simple dual-port RAM, one write port, one read port
// with a registered output (1-cycle latency). Contents are never reset.
module snapshot_bank_ram #(
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/reg_snapshot_server.sv
// Double-buffered CPU state snapshot: CPU fills the back bank, viewer reads the front
// bank (1-cycle read latency, writes refused while a swap is pending). Macro SNAP_SEQ_EN.
module reg_snapshot_server
  import snapshot_pkg::*;
#(
  parameter int          NUM_WORDS = 64,
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] OOR_VALUE = OOR_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       register_value,
  input  logic              finished_register,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  input  logic              commit,
  output logic              front_valid,
  output logic [7:0]        swap_count
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t      state, state_nxt;
  logic        front_sel;
  logic        wr_ok;
  logic        rd_in_range;
  logic [31:0] rd_data0, rd_data1;
  out_sel_t    out_sel, out_sel_nxt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // commit in PENDING/SWAP and finished_register in FILL fall through unchanged.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      FILL: begin
        wr_ready = 1'b1;
        if (commit) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (finished_register) begin
          state_nxt = SWAP;
        end
      end
      SWAP: begin
        state_nxt = FILL;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      swap_count  <= 8'd0;
    end else if (state == SWAP) begin
      front_sel   <= ~front_sel;
      front_valid <= 1'b1;
      swap_count  <= swap_count + 8'd1;
    end
  end

  // Only the back bank (the one not selected as front) ever sees writes.
  assign wr_ok = wr_en && wr_ready && (wr_addr < ADDR_W'(NUM_WORDS));

  snapshot_bank_ram #(
    .DEPTH  (NUM_WORDS),
    .IDX_W  (IDX_W),
    .DATA_W (32)
  ) u_bank0 (
    .clk     (CLOCK_50),
    .wr_en   (wr_ok && front_sel),
    .wr_addr (wr_addr[IDX_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (addr[IDX_W-1:0]),
    .rd_data (rd_data0)
  );

  snapshot_bank_ram #(
    .DEPTH  (NUM_WORDS),
    .IDX_W  (IDX_W),
    .DATA_W (32)
  ) u_bank1 (
    .clk     (CLOCK_50),
    .wr_en   (wr_ok && !front_sel),
    .wr_addr (wr_addr[IDX_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (addr[IDX_W-1:0]),
    .rd_data (rd_data1)
  );

  assign rd_in_range = addr < ADDR_W'(NUM_WORDS);

  // Bank choice is taken from front_sel at issue, so a SWAP-cycle read sees the old front.
  always_comb begin
    out_sel_nxt = OUT_OOR;
    if (front_valid && rd_in_range) begin
      out_sel_nxt = front_sel ? OUT_BANK1 : OUT_BANK0;
    end
`ifdef SNAP_SEQ_EN
    else if (front_valid && (addr == ADDR_W'(NUM_WORDS))) begin
      out_sel_nxt = OUT_SEQ;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      out_sel <= OUT_ZERO;
    end else begin
      out_sel <= out_sel_nxt;
    end
  end

`ifdef SNAP_SEQ_EN
  logic [7:0] seq_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      seq_q <= 8'd0;
    end else begin
      seq_q <= swap_count;
    end
  end
`endif

  always_comb begin
    register_value = OOR_VALUE;
    case (out_sel)
      OUT_ZERO:  register_value = 32'h0000_0000;
      OUT_BANK0: register_value = rd_data0;
      OUT_BANK1: register_value = rd_data1;
`ifdef SNAP_SEQ_EN
      OUT_SEQ:   register_value = {24'h0, seq_q};
`endif
      default:   register_value = OOR_VALUE;
    endcase
  end

endmodule

// File: tb/tb_reg_snapshot_server.sv
// Scoreboarded bench for reg_snapshot_server: a bank-level model predicts every
// viewer read; build with +define+SNAP_SEQ_EN to cover the sequence-word read.
module tb_reg_snapshot_server;

  logic        clk;
  logic        resetn;
  logic [8:0]  addr;
  logic [31:0] register_value;
  logic        finished_register;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        commit;
  logic        front_valid;
  logic [7:0]  swap_count;

  int checks;
  int failures;

  // Model state
  logic [31:0] bank_m [2][64];
  int          m_sel;
  logic        m_valid;
  logic        m_pending;
  logic [7:0]  m_swaps;
  logic [31:0] exp_q[$];

  reg_snapshot_server dut (
    .CLOCK_50          (clk),
    .resetn            (resetn),
    .addr              (addr),
    .register_value    (register_value),
    .finished_register (finished_register),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .commit            (commit),
    .front_valid       (front_valid),
    .swap_count        (swap_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_read(input int a);
    if (m_valid && a < 64) return bank_m[m_sel][a];
`ifdef SNAP_SEQ_EN
    if (m_valid && a == 64) return {24'h0, m_swaps};
`endif
    return 32'h0000_0000;
  endfunction

  task automatic rd(input int a, input string tag);
    addr = 9'(a);
    exp_q.push_back(exp_read(a));
    tick();
    check_eq(tag, register_value, exp_q.pop_front());
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 9'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (!m_pending && a < 64) bank_m[1 - m_sel][a] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_pending = 1'b1;
  endtask

  // Frame-end pulse; the read issued during the following (SWAP) cycle is checked.
  task automatic frame(input int rd_a, input string tag);
    finished_register = 1'b1;
    tick();
    finished_register = 1'b0;
    addr = 9'(rd_a);
    exp_q.push_back(exp_read(rd_a));
    tick();
    if (m_pending) begin
      m_sel     = 1 - m_sel;
      m_valid   = 1'b1;
      m_swaps   = m_swaps + 8'd1;
      m_pending = 1'b0;
    end
    check_eq(tag, register_value, exp_q.pop_front());
  endtask

  task automatic model_reset();
    m_sel     = 0;
    m_valid   = 1'b0;
    m_pending = 1'b0;
    m_swaps   = 8'd0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    addr = '0;
    finished_register = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit = 1'b0;
    model_reset();

    tick();
    tick();
    check_eq("rst_value", register_value, 32'h0);
    check_eq("rst_wr_ready", {31'b0, wr_ready}, 32'h1);
    check_eq("rst_front_valid", {31'b0, front_valid}, 32'h0);
    check_eq("rst_swap_count", {24'b0, swap_count}, 32'h0);
    resetn = 1'b1;
    tick();
    rd(5, "oor_before_commit");

    // First snapshot, plus a dropped out-of-range write that would alias word 0.
    for (int i = 0; i < 64; i++) wr(i, 32'hA000_0000 + i);
    wr(64, 32'hDEAD_BEEF);
    do_commit();
    check_eq("pend_wr_ready", {31'b0, wr_ready}, 32'h0);
    wr(3, 32'hFFFF_FFFF);
    frame(7, "swap1_cycle_read");
    check_eq("swap1_count", {24'b0, swap_count}, 32'h1);
    check_eq("swap1_valid", {31'b0, front_valid}, 32'h1);
    check_eq("swap1_wr_ready", {31'b0, wr_ready}, 32'h1);
    rd(7, "read_a7");
    rd(3, "read_a3_kept");
    rd(0, "read_a0");
    rd(63, "read_a63");
    rd(64, "read_addr64");
    rd(100, "read_oor100");
    rd(511, "read_oor511");

    // Second snapshot: commit and frame end together must not swap.
    for (int i = 0; i < 64; i++) wr(i, 32'hB000_0000 + i);
    commit = 1'b1;
    finished_register = 1'b1;
    tick();
    commit = 1'b0;
    finished_register = 1'b0;
    m_pending = 1'b1;
    tick();
    tick();
    check_eq("coincident_no_swap", {24'b0, swap_count}, 32'h1);
    check_eq("coincident_wr_ready", {31'b0, wr_ready}, 32'h0);
    rd(10, "read_old_front");
    frame(7, "swap2_cycle_old_front");
    check_eq("swap2_count", {24'b0, swap_count}, 32'h2);
    rd(7, "read_b7");
    rd(64, "read_addr64_seq2");

    // Finished pulse in FILL is ignored.
    frame(1, "ignored_frame_read");
    check_eq("fill_frame_ignored", {24'b0, swap_count}, 32'h2);

    // Pending commit lost to a mid-cycle reset; bank contents survive.
    wr(9, 32'hD000_0009);
    do_commit();
    resetn = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_swap_count", {24'b0, swap_count}, 32'h0);
    check_eq("midrst_front_valid", {31'b0, front_valid}, 32'h0);
    check_eq("midrst_wr_ready", {31'b0, wr_ready}, 32'h1);
    check_eq("midrst_value", register_value, 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    rd(0, "post_rst_read0");
    rd(64, "post_rst_read64");

    // Partial rewrite of the stale back bank.
    wr(5, 32'hC000_0005);
    do_commit();
    frame(2, "swap3_cycle_read");
    check_eq("swap3_count", {24'b0, swap_count}, 32'h1);
    rd(5, "stale_rewritten");
    rd(9, "stale_survived_reset");
    rd(6, "stale_kept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
